// File: rtl/traffic.sv
// Packet-descriptor queue that walks the head packet flit by flit on buffer.
// Optional macro TRAFFIC_SEQ_EN adds a 4-bit per-packet sequence stamp.
module traffic #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16,
  parameter int BUF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] data_in,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic [BUF_W-1:0]  buffer
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_INIT = 4'd1,
    OP_FILL = 4'd6,
    OP_DEQ  = 4'd7
  } op_e;

  typedef struct packed {
`ifdef TRAFFIC_SEQ_EN
    logic [3:0] seq;
`endif
    logic [3:0] nflit;
    logic [1:0] vc;
    logic [3:0] dst;
  } desc_t;

  desc_t          mem_q [DEPTH];
  desc_t          mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [3:0]     flit_q, flit_d;
  logic [7:0]     fill_q, fill_d;
  logic [6:0]     exp_q, exp_d;
  logic           init_q, init_d;
`ifdef TRAFFIC_SEQ_EN
  logic [3:0]     seq_q, seq_d;
`endif

  desc_t          head;
  desc_t          new_desc;
  logic           empty;
  logic           full;
  logic           is_tail;
  logic [12:0]    flit_word;
  logic           unused_data;

  assign unused_data = ^data_in;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    head    = mem_q[rd_ptr_q];
    is_tail = (flit_q == head.nflit - 4'd1);

    new_desc       = '0;
    new_desc.dst   = data_in[3:0];
    new_desc.vc    = data_in[5:4];
    new_desc.nflit = (data_in[9:6] == 4'd0) ? 4'd1 : data_in[9:6];
`ifdef TRAFFIC_SEQ_EN
    new_desc.seq   = seq_q;
`endif

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    flit_d   = flit_q;
    fill_d   = fill_q;
    exp_d    = exp_q;
    init_d   = init_q;
`ifdef TRAFFIC_SEQ_EN
    seq_d    = seq_q;
`endif

    case (op)
      OP_INIT: begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
        flit_d   = '0;
        fill_d   = '0;
        exp_d    = data_in[6:0];
        init_d   = 1'b1;
`ifdef TRAFFIC_SEQ_EN
        seq_d    = '0;
`endif
      end
      OP_FILL: begin
        if (!full) begin
          mem_d[wr_ptr_q] = new_desc;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          fill_d   = (fill_q == 8'hFF) ? fill_q : fill_q + 8'd1;
`ifdef TRAFFIC_SEQ_EN
          seq_d    = seq_q + 4'd1;
`endif
        end
      end
      OP_DEQ: begin
        if (!empty) begin
          if (is_tail) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
            flit_d   = '0;
          end else begin
            flit_d   = flit_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      flit_q   <= '0;
      fill_q   <= '0;
      exp_q    <= '0;
      init_q   <= 1'b0;
`ifdef TRAFFIC_SEQ_EN
      seq_q    <= '0;
`endif
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      flit_q   <= flit_d;
      fill_q   <= fill_d;
      exp_q    <= exp_d;
      init_q   <= init_d;
`ifdef TRAFFIC_SEQ_EN
      seq_q    <= seq_d;
`endif
    end
  end

  // Every field is gated by valid so an empty queue shows an all-zero flit.
  always_comb begin
    flit_word = '0;
    if (!empty) begin
`ifdef TRAFFIC_SEQ_EN
      flit_word[12:9] = head.seq;
`endif
      flit_word[8:5] = head.dst;
      flit_word[4:3] = head.vc;
      flit_word[2]   = is_tail;
      flit_word[1]   = (flit_q == 4'd0);
      flit_word[0]   = 1'b1;
    end
    buffer   = BUF_W'(flit_word);
    data_out = empty ? '0 : DATA_W'({head.nflit, head.vc, head.dst});
    done     = init_q && (fill_q >= {1'b0, exp_q}) && empty;
  end

endmodule

// File: tb/tb_traffic.sv
// Directed bench for traffic: expectations are queued per step and popped
// against the DUT outputs once the step's clock edge has settled.
module tb_traffic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  op = 4'd0;
  logic [15:0] data_in = 16'd0;
  logic        done;
  logic [15:0] data_out;
  logic [15:0] buffer;

  int passed = 0;
  int total  = 0;

  localparam int K_BUF = 0, K_DONE = 1, K_DOUT = 2, K_LOW3 = 3, K_SEQ = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  traffic #(.DEPTH(16), .DATA_W(16), .BUF_W(16)) dut (
    .clk(clk), .rst(rst), .op(op), .data_in(data_in),
    .done(done), .data_out(data_out), .buffer(buffer)
  );

  always #5 clk = ~clk;

  task automatic want(input string tag, input int kind, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [15:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_BUF:   o = buffer;
        K_DONE:  o = {15'd0, done};
        K_DOUT:  o = data_out;
        K_LOW3:  o = {13'd0, buffer[2:0]};
        default: o = {12'd0, buffer[12:9]};
      endcase
      total++;
      assert (o === e.val) passed++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
    end
  endtask

  task automatic do_op(input logic [3:0] o, input logic [15:0] d);
    @(negedge clk);
    op = o;
    data_in = d;
    @(posedge clk);
    #1;
    op = 4'd0;
    data_in = 16'd0;
  endtask

  function automatic logic [15:0] fill_desc(input int i);
    return 16'((i & 15) | ((i & 3) << 4) | (1 << 6));
  endfunction

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    want("rst_buf", K_BUF, 16'h0000);
    want("rst_done", K_DONE, 16'd0);
    want("rst_dout", K_DOUT, 16'h0000);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    want("post_rst_buf", K_BUF, 16'h0000);
    want("post_rst_done", K_DONE, 16'd0);
    check_all();

    want("init2_done", K_DONE, 16'd0);
    do_op(4'd1, 16'd2);
    check_all();

    // single-flit packet, upper data_in bits must be ignored
    do_op(4'd1, 16'd1);
    want("fill1_buf", K_BUF, 16'h00AF);
    want("fill1_dout", K_DOUT, 16'h0055);
    want("fill1_done", K_DONE, 16'd0);
    do_op(4'd6, 16'hFC55);
    check_all();
    want("deq1_buf", K_BUF, 16'h0000);
    want("deq1_done", K_DONE, 16'd1);
    do_op(4'd7, 16'd0);
    check_all();

    // three-flit packet
    do_op(4'd1, 16'd1);
    want("f3_low", K_LOW3, 16'b011);
    want("f3_buf", K_BUF, 16'h0073);
    do_op(4'd6, 16'h00E3);
    check_all();
    want("f3_d1", K_BUF, 16'h0071);
    do_op(4'd7, 16'd0);
    check_all();
    want("f3_d2", K_LOW3, 16'b101);
    do_op(4'd7, 16'd0);
    check_all();
    want("f3_d3_valid", K_LOW3, 16'b000);
    want("f3_d3_done", K_DONE, 16'd1);
    do_op(4'd7, 16'd0);
    check_all();

    // nflit 0 behaves as a one-flit packet
    do_op(4'd1, 16'd1);
    want("n0_buf", K_BUF, 16'h0027);
    do_op(4'd6, 16'h0001);
    check_all();
    want("n0_deq_buf", K_BUF, 16'h0000);
    want("n0_deq_done", K_DONE, 16'd1);
    do_op(4'd7, 16'd0);
    check_all();

    // reserved op codes leave state unchanged
    do_op(4'd1, 16'd1);
    do_op(4'd6, 16'h00BA);
    want("nop4_buf", K_BUF, 16'h015B);
    do_op(4'd4, 16'hFFFF);
    check_all();
    want("nop12_buf", K_BUF, 16'h015B);
    want("nop12_done", K_DONE, 16'd0);
    do_op(4'd12, 16'h0001);
    check_all();
    want("v2_d1", K_BUF, 16'h015D);
    do_op(4'd7, 16'd0);
    check_all();
    want("v2_d2_done", K_DONE, 16'd1);
    do_op(4'd7, 16'd0);
    check_all();

    // overflow: 17th fill dropped
    do_op(4'd1, 16'd20);
    for (int i = 0; i < 17; i++) do_op(4'd6, fill_desc(i));
    want("full_dout", K_DOUT, fill_desc(0));
    want("full_low", K_LOW3, 16'b111);
    want("full_done", K_DONE, 16'd0);
    check_all();
    for (int k = 1; k <= 16; k++) begin
      want($sformatf("drain%0d_dout", k), K_DOUT, (k < 16) ? fill_desc(k) : 16'h0000);
      want($sformatf("drain%0d_low", k), K_LOW3, (k < 16) ? 16'b111 : 16'b000);
      do_op(4'd7, 16'd0);
      check_all();
    end
    want("empty_deq_buf", K_BUF, 16'h0000);
    want("empty_deq_done", K_DONE, 16'd0);
    do_op(4'd7, 16'd0);
    check_all();

    // reset mid-packet
    do_op(4'd1, 16'd2);
    do_op(4'd6, 16'h0085);
    do_op(4'd6, 16'h0086);
    do_op(4'd7, 16'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    want("midrst_buf", K_BUF, 16'h0000);
    want("midrst_done", K_DONE, 16'd0);
    want("midrst_dout", K_DOUT, 16'h0000);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    want("afterrst_buf", K_BUF, 16'h0000);
    want("afterrst_done", K_DONE, 16'd0);
    check_all();
    do_op(4'd6, 16'h0045);
    do_op(4'd7, 16'd0);
    want("noinit_done", K_DONE, 16'd0);
    want("noinit_buf", K_BUF, 16'h0000);
    check_all();
    want("init0_done", K_DONE, 16'd1);
    do_op(4'd1, 16'd0);
    check_all();

    // sequence stamps
    do_op(4'd1, 16'd3);
    do_op(4'd6, 16'h0041);
    do_op(4'd6, 16'h0042);
    do_op(4'd6, 16'h0043);
    want("seq0", K_SEQ, 16'd0);
    check_all();
`ifdef TRAFFIC_SEQ_EN
    want("seq1", K_SEQ, 16'd1);
`else
    want("seq1", K_SEQ, 16'd0);
`endif
    do_op(4'd7, 16'd0);
    check_all();
`ifdef TRAFFIC_SEQ_EN
    want("seq2", K_SEQ, 16'd2);
`else
    want("seq2", K_SEQ, 16'd0);
`endif
    want("seq2_dst", K_BUF, {3'd0, 4'd0, 9'h067} | (buffer & 16'h1E00));
    do_op(4'd7, 16'd0);
    check_all();
    want("seq_done", K_DONE, 16'd1);
    do_op(4'd7, 16'd0);
    check_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
